// File: rtl/sync_fifo_pkg.sv
// Shared constants for sync_fifo_plus: reset values, COUNT width helper and
// the bit layout of the sticky error-flag vector.
package sync_fifo_pkg;

    // COUNT must represent 0..DEPTH inclusive, so it needs one bit more than a pointer.
    function automatic int unsigned cnt_width(input int unsigned addr_width);
        return addr_width + 1;
    endfunction

    // Status flag values while reset is held.
    localparam logic RstEmpty       = 1'b1;
    localparam logic RstAlmostEmpty = 1'b1;
    localparam logic RstFull        = 1'b0;
    localparam logic RstAlmostFull  = 1'b0;

    // Sticky error vector layout.
    localparam int unsigned ErrW      = 2;
    localparam int unsigned ErrOvfIdx = 0;
    localparam int unsigned ErrUdfIdx = 1;
    localparam logic [ErrW-1:0] ErrNone = 2'b00;

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset.
module fifo_ram #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Write port; contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_plus.sv
// Single-clock FIFO with registered status flags, flush and sticky error flags.
// Read mode: define SYNC_FIFO_PLUS_FWFT_EN for first-word-fall-through,
// otherwise RD_DATA is registered with one cycle of latency.
module sync_fifo_plus
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned AF_LEVEL   = 12,
    parameter int unsigned AE_LEVEL   = 2
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    W_INC,
    input  logic [DATA_WIDTH-1:0]   WR_DATA,
    input  logic                    R_INC,
    output logic [DATA_WIDTH-1:0]   RD_DATA,
    input  logic                    FLUSH,
    input  logic                    CLR_ERR,
    output logic                    FULL,
    output logic                    EMPTY,
    output logic                    ALMOST_FULL,
    output logic                    ALMOST_EMPTY,
    output logic [ADDR_WIDTH:0]     COUNT,
    output logic                    OVERFLOW,
    output logic                    UNDERFLOW
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned CntW  = cnt_width(ADDR_WIDTH);

    localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);
    localparam logic [CntW-1:0] AfC    = CntW'(AF_LEVEL);
    localparam logic [CntW-1:0] AeC    = CntW'(AE_LEVEL);

    if (!((AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH))) begin : g_bad_levels
        $fatal(1, "sync_fifo_plus: need AE_LEVEL < AF_LEVEL <= DEPTH");
    end

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic                  full_q, empty_q, af_q, ae_q;
    logic [ErrW-1:0]       err_q, err_d, err_ev;
    logic                  rd_acc, wr_acc;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // Transfer acceptance and next-state for pointers, occupancy and error flags.
    always_comb begin
        rd_acc   = R_INC && !empty_q;
        // A full FIFO still takes a write when a read frees a slot on the same edge.
        wr_acc   = W_INC && (!full_q || rd_acc);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_ev   = ErrNone;
        if (FLUSH) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
            if (wr_acc && !rd_acc) begin
                count_d = count_q + CntW'(1);
            end else if (rd_acc && !wr_acc) begin
                count_d = count_q - CntW'(1);
            end
            err_ev[ErrOvfIdx] = W_INC && !wr_acc;
            err_ev[ErrUdfIdx] = R_INC && !rd_acc;
        end
        // New error events win over a same-cycle clear.
        err_d = (CLR_ERR ? ErrNone : err_q) | err_ev;
    end

    // State registers; flags derive from next occupancy so they track COUNT exactly.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= RstFull;
            empty_q  <= RstEmpty;
            af_q     <= RstAlmostFull;
            ae_q     <= RstAlmostEmpty;
            err_q    <= ErrNone;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == DepthC);
            empty_q  <= (count_d == '0);
            af_q     <= (count_d >= AfC);
            ae_q     <= (count_d <= AeC);
            err_q    <= err_d;
        end
    end

    fifo_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk_i   (CLK),
        .we_i    (wr_acc && !FLUSH),
        .waddr_i (wr_ptr_q),
        .wdata_i (WR_DATA),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

`ifdef SYNC_FIFO_PLUS_FWFT_EN
    // Head word is visible whenever data is present; zero while empty.
    assign RD_DATA = empty_q ? '0 : ram_rdata;
`else
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Capture the head word on an accepted read; hold otherwise.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_data_q <= '0;
        end else if (rd_acc && !FLUSH) begin
            rd_data_q <= ram_rdata;
        end
    end

    assign RD_DATA = rd_data_q;
`endif

    assign COUNT        = count_q;
    assign FULL         = full_q;
    assign EMPTY        = empty_q;
    assign ALMOST_FULL  = af_q;
    assign ALMOST_EMPTY = ae_q;
    assign OVERFLOW     = err_q[ErrOvfIdx];
    assign UNDERFLOW    = err_q[ErrUdfIdx];

endmodule

// File: tb/tb_sync_fifo_plus.sv
// Self-checking bench for sync_fifo_plus; works in both read modes
// (SYNC_FIFO_PLUS_FWFT_EN defined or not).
module tb_sync_fifo_plus;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       W_INC = 1'b0;
    logic [7:0] WR_DATA = 8'h00;
    logic       R_INC = 1'b0;
    logic [7:0] RD_DATA;
    logic       FLUSH = 1'b0;
    logic       CLR_ERR = 1'b0;
    logic       FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY;
    logic [4:0] COUNT;
    logic       OVERFLOW, UNDERFLOW;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    sync_fifo_plus #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(4),
        .AF_LEVEL  (12),
        .AE_LEVEL  (2)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .W_INC        (W_INC),
        .WR_DATA      (WR_DATA),
        .R_INC        (R_INC),
        .RD_DATA      (RD_DATA),
        .FLUSH        (FLUSH),
        .CLR_ERR      (CLR_ERR),
        .FULL         (FULL),
        .EMPTY        (EMPTY),
        .ALMOST_FULL  (ALMOST_FULL),
        .ALMOST_EMPTY (ALMOST_EMPTY),
        .COUNT        (COUNT),
        .OVERFLOW     (OVERFLOW),
        .UNDERFLOW    (UNDERFLOW)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of stored words plus sticky flags.
    logic [7:0] mq[$];
    bit         m_ovf, m_udf;
    logic [7:0] m_rd;

    always @(posedge CLK or posedge RST) begin
        bit ra, wa, ovf_ev, udf_ev;
        if (RST) begin
            mq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
            m_rd  = 8'h00;
        end else begin
            ra = 1'b0;
            wa = 1'b0;
            ovf_ev = 1'b0;
            udf_ev = 1'b0;
            if (FLUSH) begin
                mq.delete();
            end else begin
                ra = R_INC && (mq.size() > 0);
                wa = W_INC && ((mq.size() < 16) || ra);
                ovf_ev = W_INC && !wa;
                udf_ev = R_INC && !ra;
                if (ra) m_rd = mq.pop_front();
                if (wa) mq.push_back(WR_DATA);
            end
            m_ovf = ovf_ev ? 1'b1 : (CLR_ERR ? 1'b0 : m_ovf);
            m_udf = udf_ev ? 1'b1 : (CLR_ERR ? 1'b0 : m_udf);
        end
    end

    function automatic logic [7:0] exp_rd();
`ifdef SYNC_FIFO_PLUS_FWFT_EN
        return (mq.size() > 0) ? mq[0] : 8'h00;
`else
        return m_rd;
`endif
    endfunction

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("m_count", 32'(COUNT), 32'(mq.size()));
            chk("m_full", 32'(FULL), 32'(mq.size() == 16));
            chk("m_empty", 32'(EMPTY), 32'(mq.size() == 0));
            chk("m_afull", 32'(ALMOST_FULL), 32'(mq.size() >= 12));
            chk("m_aempty", 32'(ALMOST_EMPTY), 32'(mq.size() <= 2));
            chk("m_ovf", 32'(OVERFLOW), 32'(m_ovf));
            chk("m_udf", 32'(UNDERFLOW), 32'(m_udf));
            chk("m_rddata", 32'(RD_DATA), 32'(exp_rd()));
        end
    end

    // One clock of stimulus; 'got' is the word delivered by a read in this cycle
    // (before the edge in FWFT mode, after it in registered mode).
    task automatic step(input logic w, input logic [7:0] wd, input logic r, input logic fl,
                        input logic ce, output logic [7:0] got);
`ifdef SYNC_FIFO_PLUS_FWFT_EN
        got = RD_DATA;
`endif
        W_INC = w; WR_DATA = wd; R_INC = r; FLUSH = fl; CLR_ERR = ce;
        @(posedge CLK);
        #1;
        W_INC = 1'b0; R_INC = 1'b0; FLUSH = 1'b0; CLR_ERR = 1'b0;
`ifndef SYNC_FIFO_PLUS_FWFT_EN
        got = RD_DATA;
`endif
    endtask

    initial begin
        logic [7:0] g;
        int k, peak;
        #1 RST = 1'b1;
        #1 chk_en = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        chk("rst_empty", 32'(EMPTY), 1);
        chk("rst_aempty", 32'(ALMOST_EMPTY), 1);
        chk("rst_count", 32'(COUNT), 0);
        chk("rst_rddata", 32'(RD_DATA), 0);

        // Read while empty.
        step(1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, g);
        chk("uf_empty", 32'(EMPTY), 1);
        chk("uf_set", 32'(UNDERFLOW), 1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, g);
        chk("uf_clr", 32'(UNDERFLOW), 0);

        // Fill 0x00..0x0F.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, g);
            if (i == 1) chk("ae_at2", 32'(ALMOST_EMPTY), 1);
            if (i == 2) chk("ae_at3", 32'(ALMOST_EMPTY), 0);
            if (i == 10) chk("af_at11", 32'(ALMOST_FULL), 0);
            if (i == 11) chk("af_at12", 32'(ALMOST_FULL), 1);
        end
        chk("full16", 32'(FULL), 1);
        chk("count16", 32'(COUNT), 16);
        step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, g);
        chk("ovf_set", 32'(OVERFLOW), 1);
        chk("ovf_count", 32'(COUNT), 16);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, g);
        chk("ovf_clr", 32'(OVERFLOW), 0);

        // Simultaneous write/read at full, then drain across the wrap.
        step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, g);
        chk("wr_rd_full_data", 32'(g), 32'h00);
        chk("wr_rd_full_cnt", 32'(COUNT), 16);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, g);
            chk("drain", 32'(g), (i < 15) ? 32'(i + 1) : 32'h55);
        end
        chk("drain_empty", 32'(EMPTY), 1);
        chk("drain_uf", 32'(UNDERFLOW), 0);

        // 10-word packet, one write per cycle, read every 2nd cycle.
        k = 0;
        peak = 0;
        for (int c = 0; c < 20; c++) begin
            step(1'b1 && (c < 10), 8'(8'h30 + c), (c % 2) == 1, 1'b0, 1'b0, g);
            if ((c % 2) == 1) begin
                chk("pkt_data", 32'(g), 32'(8'h30 + k));
                k++;
            end
            if (int'(COUNT) > peak) peak = int'(COUNT);
        end
        chk("pkt_reads", 32'(k), 10);
        chk("pkt_peak_le6", 32'(peak <= 6), 1);
        chk("pkt_ovf", 32'(OVERFLOW), 0);
        chk("pkt_udf", 32'(UNDERFLOW), 0);
        chk("pkt_empty", 32'(EMPTY), 1);

        // Flush at COUNT=5 with a concurrent write.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0, g);
        chk("pre_flush_cnt", 32'(COUNT), 5);
        step(1'b1, 8'h99, 1'b0, 1'b1, 1'b0, g);
        chk("flush_cnt", 32'(COUNT), 0);
        chk("flush_empty", 32'(EMPTY), 1);
        chk("flush_ovf", 32'(OVERFLOW), 0);

        // Error event beats clear; write still accepted alongside a rejected read.
        step(1'b1, 8'h12, 1'b1, 1'b0, 1'b1, g);
        chk("clr_vs_uf", 32'(UNDERFLOW), 1);
        chk("uf_wr_cnt", 32'(COUNT), 1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, g);
        chk("uf_wr_data", 32'(g), 32'h12);
        chk("clr_after", 32'(UNDERFLOW), 0);

        // Reset in the middle of a write.
        W_INC = 1'b1;
        WR_DATA = 8'h77;
        #2 RST = 1'b1;
        @(posedge CLK);
        #1;
        chk("midrst_cnt", 32'(COUNT), 0);
        chk("midrst_empty", 32'(EMPTY), 1);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        W_INC = 1'b0;
        chk("postrst_cnt", 32'(COUNT), 1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, g);
        chk("postrst_data", 32'(g), 32'h77);

        repeat (2) @(posedge CLK);
        #1;
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo_plus.md
SYNC_FIFO_PLUS -- requirements
Module: sync_fifo_plus

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 SHALL provide parameter ADDR_WIDTH, default 4, pointer width; DEPTH = 2**ADDR_WIDTH words.
REQ-003 SHALL provide parameter AF_LEVEL, default 12, occupancy at or above which ALMOST_FULL asserts.
REQ-004 SHALL provide parameter AE_LEVEL, default 2, occupancy at or below which ALMOST_EMPTY asserts.
REQ-005 SHALL have ports, one per line: name  direction  width  meaning.
- CLK  in  1  single clock; all logic on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- W_INC  in  1  write request.
- WR_DATA  in  DATA_WIDTH  write word.
- R_INC  in  1  read request.
- RD_DATA  out  DATA_WIDTH  read word.
- FLUSH  in  1  synchronous empty command.
- CLR_ERR  in  1  clears sticky error flags.
- FULL  out  1  COUNT == DEPTH.
- EMPTY  out  1  COUNT == 0.
- ALMOST_FULL  out  1  COUNT >= AF_LEVEL.
- ALMOST_EMPTY  out  1  COUNT <= AE_LEVEL.
- COUNT  out  ADDR_WIDTH+1  current occupancy.
- OVERFLOW  out  1  sticky; a write was rejected.
- UNDERFLOW  out  1  sticky; a read was rejected.

Function
REQ-006 SHALL accept a write on an edge with W_INC=1 and (FULL=0, or R_INC=1 with the read accepted); WR_DATA is stored at the write pointer and the pointer increments.
REQ-007 SHALL accept a read on an edge with R_INC=1 and EMPTY=0; the read pointer increments.
REQ-008 SHALL ignore W_INC at FULL without an accepted read, with no state change except OVERFLOW<=1.
REQ-009 SHALL ignore R_INC at EMPTY and set UNDERFLOW<=1; a simultaneous write is still accepted.
REQ-010 SHALL update COUNT as follows: write only +1, read only -1, both or neither unchanged; COUNT never leaves 0..DEPTH.
REQ-011 SHALL wrap pointers modulo DEPTH with no bubble.
REQ-012 SHALL register FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY and COUNT, all consistent in the same cycle and valid one edge after the causing transfer.
REQ-013 SHALL, on FLUSH=1, zero both pointers and COUNT at that edge; FLUSH has priority over W_INC/R_INC in the same cycle, which are dropped without error flags.
REQ-014 SHALL clear OVERFLOW/UNDERFLOW on CLR_ERR=1; a new error event in the same cycle takes priority and holds the flag at 1.
REQ-015 SHALL hold RD_DATA stable when no read is accepted.

Reset
REQ-016 SHALL, while RST=1, asynchronously force pointers=0, COUNT=0, EMPTY=1, ALMOST_EMPTY=1, FULL=0, ALMOST_FULL=0, OVERFLOW=0, UNDERFLOW=0, RD_DATA=0; memory contents are not reset.
REQ-017 SHALL accept a reset mid-transfer; the in-flight transfer is discarded, and the first edge after RST falls is a normal cycle.

Configuration
REQ-018 SHALL use macro SYNC_FIFO_PLUS_FWFT_EN to select read mode.
REQ-019 SHALL, with the macro defined, use first-word-fall-through: RD_DATA shows the head word combinationally whenever EMPTY=0, and an accepted read advances to the next word.
REQ-020 SHALL, with the macro undefined, use registered read: RD_DATA is loaded with the head word on the accepted-read edge, giving 1-cycle latency.

Structure
REQ-021 SHALL place reset constants, the COUNT width function and error-flag encoding in package sync_fifo_pkg.
REQ-022 SHALL instantiate one sub-module, fifo_ram, a DEPTH x DATA_WIDTH simple dual-port memory with synchronous write and asynchronous read.
REQ-023 SHALL elaborate-time check AE_LEVEL < AF_LEVEL <= DEPTH.

Verification (DATA_WIDTH=8, ADDR_WIDTH=4, AF 12, AE 2)
REQ-024 SHALL cover a reset pulse followed by a read of 8'hA5: EMPTY=1 and UNDERFLOW=1, and after CLR_ERR UNDERFLOW=0.
REQ-025 SHALL cover writing 16 words 0x00..0x0F: ALMOST_EMPTY drops after the 3rd write, ALMOST_FULL rises after the 12th, FULL=1 and COUNT=16 after the 16th, and a 17th write sets OVERFLOW with memory unchanged.
REQ-026 SHALL cover, at FULL, W_INC=R_INC=1 with 0x55: COUNT stays 16, 0x00 is read, and 0x55 is read last after wrap.
REQ-027 SHALL cover a 10-word packet written at 1/cycle while reading every 2nd or 3rd cycle: the read data matches the write order, COUNT peaks at 6 or less, and no flags are set.
REQ-028 SHALL cover FLUSH at COUNT=5 together with W_INC=1: next cycle COUNT=0, EMPTY=1, and OVERFLOW=0.
REQ-029 SHALL run every scenario in both FWFT and registered builds, checking RD_DATA latency of 0 and 1 cycles respectively.
